// File: rtl/matrix_capture_if.sv
// Pin and readback bundle for the LED-matrix capture block.
// master = pin driver / reader side, slave = the capture block.
interface matrix_capture_if #(
    parameter int CNT_W = 8
);
    logic             cclk;
    logic             csdi;
    logic             le;
    logic             rclk;
    logic             rsdi;
    logic             oeb;
    logic [3:0]       rd_row;
    logic             err_clr;
    logic [15:0]      rd_data;
    logic [15:0]      row_sel;
    logic [3:0]       cur_row;
    logic             row_valid;
    logic             frame_done;
    logic [CNT_W-1:0] frame_count;
    logic             proto_err;

    modport master (
        output cclk, csdi, le, rclk, rsdi, oeb, rd_row, err_clr,
        input  rd_data, row_sel, cur_row, row_valid, frame_done, frame_count, proto_err
    );

    modport slave (
        input  cclk, csdi, le, rclk, rsdi, oeb, rd_row, err_clr,
        output rd_data, row_sel, cur_row, row_valid, frame_done, frame_count, proto_err
    );
endinterface

// File: rtl/matrix_capture.sv
// Snoops the 16x16 LED-matrix serial pins and rebuilds the displayed frame.
// Define MATRIX_CAPTURE_OEB_QUAL_EN to commit rows on OEB fall instead of LE rise.
module matrix_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    matrix_capture_if.slave bus
);
    localparam int NP = 6;

    logic [NP-1:0]    pins;
    logic [NP-1:0]    sync_q [SYNC_STAGES];
    logic [NP-1:0]    sync_d [SYNC_STAGES];
    logic [NP-1:0]    prev_q, prev_d, pin_s;
    logic [15:0]      col_sr_q, col_sr_d;
    logic [15:0]      row_sel_q, row_sel_d;
    logic [15:0]      col_latch_q, col_latch_d;
    logic [15:0]      frame_q [16];
    logic [15:0]      frame_d [16];
    logic [15:0]      rd_data_q, rd_data_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic             proto_err_q, proto_err_d;
    logic             cclk_rise, le_rise, rclk_rise, oeb_fall;
    logic             row_valid, wr_ev;
    logic [3:0]       cur_row;
    logic [15:0]      wr_data;

    // Pin order: {oeb, rsdi, rclk, le, csdi, cclk}
    assign pins = {bus.oeb, bus.rsdi, bus.rclk, bus.le, bus.csdi, bus.cclk};

    always_comb begin
        sync_d[0] = pins;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        pin_s  = sync_q[SYNC_STAGES-1];
        prev_d = pin_s;
    end

    assign cclk_rise = pin_s[0] & ~prev_q[0];
    assign le_rise   = pin_s[2] & ~prev_q[2];
    assign rclk_rise = pin_s[3] & ~prev_q[3];
    assign oeb_fall  = ~pin_s[5] & prev_q[5];

`ifndef MATRIX_CAPTURE_OEB_QUAL_EN
    logic unused_oeb;
    assign unused_oeb = oeb_fall;
`endif

    assign row_valid = (row_sel_q != 16'd0) && ((row_sel_q & (row_sel_q - 16'd1)) == 16'd0);

    always_comb begin
        cur_row = 4'd0;
        if (row_valid) begin
            for (int i = 0; i < 16; i++) if (row_sel_q[i]) cur_row = 4'(i);
        end
    end

    always_comb begin
        col_sr_d      = cclk_rise ? {col_sr_q[14:0], pin_s[1]} : col_sr_q;
        row_sel_d     = rclk_rise ? {row_sel_q[14:0], pin_s[4]} : row_sel_q;
        col_latch_d   = le_rise ? col_sr_q : col_latch_q;
        frame_d       = frame_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        proto_err_d   = bus.err_clr ? 1'b0 : proto_err_q;
        // Write source and row are the pre-shift values when edges coincide.
`ifdef MATRIX_CAPTURE_OEB_QUAL_EN
        wr_ev   = oeb_fall;
        wr_data = col_latch_d;
`else
        wr_ev   = le_rise;
        wr_data = col_sr_q;
`endif
        if (wr_ev) begin
            if (row_valid) begin
                frame_d[cur_row] = wr_data;
                if (cur_row == 4'd15) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 1'b1;
                end
            end else begin
                proto_err_d = 1'b1;
            end
        end
        rd_data_d = frame_q[bus.rd_row];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < 16; i++) frame_q[i] <= '0;
            prev_q        <= '0;
            col_sr_q      <= '0;
            row_sel_q     <= '0;
            col_latch_q   <= '0;
            rd_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            for (int i = 0; i < 16; i++) frame_q[i] <= frame_d[i];
            prev_q        <= prev_d;
            col_sr_q      <= col_sr_d;
            row_sel_q     <= row_sel_d;
            col_latch_q   <= col_latch_d;
            rd_data_q     <= rd_data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.row_sel     = row_sel_q;
    assign bus.cur_row     = cur_row;
    assign bus.row_valid   = row_valid;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;
    assign bus.proto_err   = proto_err_q;
endmodule

// File: tb/tb_matrix_capture.sv
// Bench for matrix_capture: pin-level driver, event-level frame model, per-cycle compare.
module tb_matrix_capture;
  localparam int CNT_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  matrix_capture_if #(.CNT_W(CNT_W)) bus ();
  matrix_capture #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // pins = {oeb, rsdi, rclk, le, csdi, cclk}
  logic [5:0] pins = 6'b100000;
  logic [3:0] rd_row = 4'd0;
  logic err_clr = 1'b0;
  assign bus.cclk = pins[0];
  assign bus.csdi = pins[1];
  assign bus.le = pins[2];
  assign bus.rclk = pins[3];
  assign bus.rsdi = pins[4];
  assign bus.oeb = pins[5];
  assign bus.rd_row = rd_row;
  assign bus.err_clr = err_clr;

  // behavioural model of the displayed frame
  logic [15:0] m_col, m_row, m_latch;
  logic [15:0] m_frame [16];
  bit m_err;
  int m_count, m_done, dut_done;
  bit settled = 1'b0;
  int total = 0, bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return $countones(m_row) == 1;
  endfunction

  function automatic int m_idx();
    int r;
    r = 0;
    if (m_valid())
      for (int i = 0; i < 16; i++) if (m_row[i]) r = i;
    return r;
  endfunction

  task automatic model_apply(input logic [5:0] op, input logic [5:0] np, input bit clr);
    bit cr, ler, rr, wr;
    logic [15:0] data;
    cr = np[0] && !op[0];
    ler = np[2] && !op[2];
    rr = np[3] && !op[3];
    wr = 0;
    data = m_col;
    if (clr) m_err = 0;
    if (ler) m_latch = m_col;
`ifdef MATRIX_CAPTURE_OEB_QUAL_EN
    if (op[5] && !np[5]) begin wr = 1; data = m_latch; end
`else
    if (ler) begin wr = 1; data = m_col; end
`endif
    if (wr) begin
      if (m_valid()) begin
        m_frame[m_idx()] = data;
        if (m_idx() == 15) begin
          m_count = (m_count + 1) % (1 << CNT_W);
          m_done++;
        end
      end else m_err = 1;
    end
    if (cr) m_col = {m_col[14:0], np[1]};
    if (rr) m_row = {m_row[14:0], np[4]};
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (bus.frame_done) dut_done++;
    if (reset_n && settled) begin
      check("row_sel", 32'(bus.row_sel), 32'(m_row));
      check("cur_row", 32'(bus.cur_row), 32'(m_idx()));
      check("row_valid", 32'(bus.row_valid), 32'(m_valid()));
      check("proto_err", 32'(bus.proto_err), 32'(m_err));
      check("frame_count", 32'(bus.frame_count), 32'(m_count));
      check("rd_data", 32'(bus.rd_data), 32'(m_frame[rd_row]));
      check("frame_done_count", 32'(dut_done), 32'(m_done));
    end
  end

  // driver tasks
  task automatic step(input logic [5:0] np, input bit clr);
    @(posedge clk); #1;
    settled = 0;
    model_apply(pins, np, clr);
    pins = np;
    @(posedge clk); @(posedge clk); #1;
    if (clr) err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    @(posedge clk); #1;
    settled = 1;
  endtask

  task automatic set_pin(input int idx, input bit v);
    logic [5:0] np;
    np = pins;
    np[idx] = v;
    step(np, 0);
  endtask

  task automatic shift_col(input logic [15:0] v);
    for (int b = 15; b >= 0; b--) begin
      logic [5:0] np;
      np = pins; np[0] = 0; np[1] = v[b];
      step(np, 0);
      set_pin(0, 1);
    end
  endtask

  task automatic set_row_val(input logic [15:0] v);
    for (int b = 15; b >= 0; b--) begin
      logic [5:0] np;
      np = pins; np[3] = 0; np[4] = v[b];
      step(np, 0);
      set_pin(3, 1);
    end
  endtask

  task automatic set_row(input int idx);
    set_row_val(16'(1) << idx);
  endtask

  task automatic shift_row_zero();
    logic [5:0] np;
    np = pins; np[3] = 0; np[4] = 0;
    step(np, 0);
    set_pin(3, 1);
  endtask

  task automatic le_pulse();
    set_pin(2, 1);
    set_pin(2, 0);
`ifdef MATRIX_CAPTURE_OEB_QUAL_EN
    set_pin(5, 0);
    set_pin(5, 1);
`endif
  endtask

  task automatic set_rd(input logic [3:0] r);
    @(posedge clk); #1;
    settled = 0;
    rd_row = r;
    @(posedge clk); @(posedge clk); #1;
    settled = 1;
  endtask

  task automatic clear_err();
    @(posedge clk); #1;
    settled = 0;
    err_clr = 1;
    m_err = 0;
    @(posedge clk); #1;
    err_clr = 0;
    @(posedge clk); #1;
    settled = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 0;
    settled = 0;
    pins = 6'b100000;
    rd_row = 0;
    err_clr = 0;
    m_col = 0; m_row = 0; m_latch = 0; m_err = 0; m_count = 0;
    for (int i = 0; i < 16; i++) m_frame[i] = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_row_sel", 32'(bus.row_sel), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_frame_count", 32'(bus.frame_count), 0);
    check("rst_proto_err", 32'(bus.proto_err), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_row_valid", 32'(bus.row_valid), 0);
    check("rst_cur_row", 32'(bus.cur_row), 0);
    reset_n = 1;
    repeat (4) @(posedge clk);
    #1 settled = 1;
  endtask

  initial begin
    int done0;
    m_done = 0;
    dut_done = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // single row write
    shift_col(16'hA5A5);
    set_row(3);
    le_pulse();
    set_rd(3);
    check("t1_rd_data", 32'(bus.rd_data), 32'h0000A5A5);
    check("t1_cur_row", 32'(bus.cur_row), 3);
    check("t1_row_valid", 32'(bus.row_valid), 1);
    check("t1_proto_err", 32'(bus.proto_err), 0);

    // checkerboard frame
    done0 = dut_done;
    set_row(0);
    for (int r = 0; r < 16; r++) begin
      shift_col((r % 2) ? 16'hAAAA : 16'h5555);
      le_pulse();
      shift_row_zero();
    end
    for (int r = 0; r < 16; r++) exp_q.push_back((r % 2) ? 16'hAAAA : 16'h5555);
    for (int r = 0; r < 16; r++) begin
      logic [15:0] e;
      set_rd(4'(r));
      e = exp_q.pop_front();
      check("t2_row", 32'(bus.rd_data), 32'(e));
    end
    check("t2_frame_count", 32'(bus.frame_count), 1);
    check("t2_done_pulses", 32'(dut_done - done0), 1);

    // frame_count wrap: 255 more row-15 writes
    set_row(15);
    repeat (255) le_pulse();
    check("t2_count_wrap", 32'(bus.frame_count), 0);

    // protocol errors
    set_row_val(16'h0003);
    le_pulse();
    check("t3_err_set", 32'(bus.proto_err), 1);
    set_rd(0);
    check("t3_row0_kept", 32'(bus.rd_data), 32'h00005555);
    set_rd(1);
    check("t3_row1_kept", 32'(bus.rd_data), 32'h0000AAAA);
    clear_err();
    check("t3_err_clr", 32'(bus.proto_err), 0);
    set_row_val(16'h0000);
`ifdef MATRIX_CAPTURE_OEB_QUAL_EN
    set_pin(2, 1);
    set_pin(2, 0);
    step(pins & ~6'b100000, 1);
    set_pin(5, 1);
`else
    step(pins | 6'b000100, 1);
    set_pin(2, 0);
`endif
    check("t3_err_clr_vs_set", 32'(bus.proto_err), 1);

    // CCLK and LE rise together
    set_row(9);
    shift_col(16'h1234);
    step({pins[5:2], 1'b1, 1'b0}, 0);
    step({pins[5:3], 1'b1, pins[1], 1'b1}, 0);
    set_pin(2, 0);
`ifdef MATRIX_CAPTURE_OEB_QUAL_EN
    set_pin(5, 0);
    set_pin(5, 1);
`endif
    set_rd(9);
    check("t4_pre_shift", 32'(bus.rd_data), 32'h00001234);
    le_pulse();
    check("t4_post_shift", 32'(bus.rd_data), 32'h00002469);

    // reset mid-row
    done0 = dut_done;
    for (int b = 0; b < 7; b++) begin
      step({pins[5:2], b[0], 1'b0}, 0);
      set_pin(0, 1);
    end
    do_reset();
    for (int r = 0; r < 16; r++) begin
      set_rd(4'(r));
      check("t5_row_zero", 32'(bus.rd_data), 0);
    end
    check("t5_no_done", 32'(dut_done - done0), 0);
    set_row(2);
    shift_col(16'hBEEF);
    le_pulse();
    set_rd(2);
    check("t5_row_after", 32'(bus.rd_data), 32'h0000BEEF);

    // OEB qualification
    set_row(6);
    shift_col(16'h3C3C);
    set_rd(6);
    set_pin(2, 1);
`ifdef MATRIX_CAPTURE_OEB_QUAL_EN
    check("t6_le_no_write", 32'(bus.rd_data), 0);
`else
    check("t6_le_write", 32'(bus.rd_data), 32'h00003C3C);
`endif
    set_pin(2, 0);
    set_pin(5, 0);
    check("t6_after_oeb", 32'(bus.rd_data), 32'h00003C3C);
    set_pin(5, 1);

    // randomized pin activity
    repeat (400) begin
      logic [5:0] np, flip;
      if ($urandom_range(0, 3) != 0) flip = 6'(1) << $urandom_range(0, 5);
      else flip = 6'($urandom_range(0, 63));
      np = pins ^ flip;
      if (np[0] && !pins[0]) np[1] = pins[1];
      if (np[3] && !pins[3]) np[4] = pins[4];
      step(np, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) set_rd(4'($urandom_range(0, 15)));
    end
    for (int r = 0; r < 16; r++) set_rd(4'(r));

    settled = 0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
